// File: rtl/lsu.sv
// lsu: RV32I byte/half/word load-store unit in front of a word-addressed dmem port.
// Define LSU_MISALIGN_EN to allow misaligned accesses; word-crossing ones split into two beats.
module lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_wmask,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [3:0] size_lanes(input logic [1:0] sz);
        case (sz)
            2'd0:    size_lanes = 4'b0001;
            2'd1:    size_lanes = 4'b0011;
            2'd2:    size_lanes = 4'b1111;
            default: size_lanes = 4'b0000;
        endcase
    endfunction

    function automatic logic illegal_funct3(input logic we, input logic [2:0] f3);
        if (we) begin
            illegal_funct3 = f3[2] || (f3[1:0] == 2'd3);
        end else begin
            illegal_funct3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'd0);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lanes_to_mask(input logic [3:0] lanes);
        lanes_to_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    extend_load = {{24{raw[7]}}, raw[7:0]};
            3'd1:    extend_load = {{16{raw[15]}}, raw[15:0]};
            3'd2:    extend_load = raw;
            3'd4:    extend_load = {24'h000000, raw[7:0]};
            3'd5:    extend_load = {16'h0000, raw[15:0]};
            default: extend_load = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic        we_r, err_r, split_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  lanes_hi_r;
    logic [31:0] asm_r, asm_s;

    logic        req_err_s, req_split_s;
    logic [7:0]  req_lanes_s;
    logic [2:0]  hi_bytes_s;

    logic        req_ready_s, resp_valid_s, resp_err_s, mem_we_s;
    logic [31:0] resp_rdata_s, mem_a_s, mem_wd_s, mem_wmask_s;
    logic        req_ready_r, resp_valid_r, resp_err_r, mem_we_r;
    logic [31:0] resp_rdata_r, mem_a_r, mem_wd_r, mem_wmask_r;

    // Classify the incoming request: byte lanes over two words, error, and split
    always_comb begin
        req_lanes_s = {4'b0000, size_lanes(req_funct3[1:0])} << req_addr[1:0];
`ifdef LSU_MISALIGN_EN
        req_err_s   = illegal_funct3(req_we, req_funct3);
        req_split_s = !req_err_s && (req_lanes_s[7:4] != 4'b0000);
`else
        req_err_s   = illegal_funct3(req_we, req_funct3) ||
                      misaligned(req_funct3[1:0], req_addr[1:0]);
        req_split_s = 1'b0;
`endif
    end

    // Number of bytes of the word that land in the lower part of a split access
    always_comb begin
        hi_bytes_s = 3'd4 - {1'b0, addr_r[1:0]};
    end

    // Load assembly: BEAT0 brings the low bytes down, BEAT1 ORs in the spill-over
    always_comb begin
        asm_s = asm_r;
        if (!we_r && (state_r == BEAT0)) begin
            asm_s = mem_rd >> {addr_r[1:0], 3'b000};
        end else if (!we_r && (state_r == BEAT1)) begin
            asm_s = asm_r | (mem_rd << {hi_bytes_s, 3'b000});
        end else begin
            asm_s = asm_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = req_valid ? BEAT0 : IDLE;
            BEAT0:   state_s = split_r ? BEAT1 : RESP;
            BEAT1:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output values for the state being entered; registered below
    always_comb begin
        req_ready_s  = 1'b0;
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        mem_we_s     = 1'b0;
        mem_a_s      = mem_a_r;
        mem_wd_s     = 32'h0000_0000;
        mem_wmask_s  = 32'h0000_0000;
        case (state_s)
            IDLE: begin
                req_ready_s = 1'b1;
            end
            BEAT0: begin
                mem_a_s     = {req_addr[31:2], 2'b00};
                mem_we_s    = req_we && !req_err_s;
                mem_wd_s    = req_wdata << {req_addr[1:0], 3'b000};
                mem_wmask_s = req_err_s ? 32'h0000_0000 : lanes_to_mask(req_lanes_s[3:0]);
            end
            BEAT1: begin
                mem_a_s     = {addr_r[31:2], 2'b00} + 32'd4;
                mem_we_s    = we_r;
                mem_wd_s    = wdata_r >> {hi_bytes_s, 3'b000};
                mem_wmask_s = lanes_to_mask(lanes_hi_r);
            end
            RESP: begin
                resp_valid_s = 1'b1;
                resp_err_s   = err_r;
                resp_rdata_s = (we_r || err_r) ? 32'h0000_0000 : extend_load(funct3_r, asm_s);
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Latch the request on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r       <= 1'b0;
            funct3_r   <= 3'd0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            split_r    <= 1'b0;
            lanes_hi_r <= 4'b0000;
        end else if ((state_r == IDLE) && req_valid) begin
            we_r       <= req_we;
            funct3_r   <= req_funct3;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            err_r      <= req_err_s;
            split_r    <= req_split_s;
            lanes_hi_r <= req_lanes_s[7:4];
        end
    end

    // Load assembly register
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_r <= 32'h0000_0000;
        end else begin
            asm_r <= asm_s;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            mem_we_r     <= 1'b0;
            mem_a_r      <= 32'h0000_0000;
            mem_wd_r     <= 32'h0000_0000;
            mem_wmask_r  <= 32'h0000_0000;
        end else begin
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_err_r   <= resp_err_s;
            resp_rdata_r <= resp_rdata_s;
            mem_we_r     <= mem_we_s;
            mem_a_r      <= mem_a_s;
            mem_wd_r     <= mem_wd_s;
            mem_wmask_r  <= mem_wmask_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    // A reset arriving mid-beat must keep dmem from committing that beat's write
    assign mem_we     = mem_we_r && !reset;
    assign mem_a      = mem_a_r;
    assign mem_wd     = mem_wd_r;
    assign mem_wmask  = mem_wmask_r;

endmodule
